// File: rtl/load_commit_buffer_pkg.sv
// Shared types and constants for the load-completion receive buffer.
package load_commit_buffer_pkg;

    localparam int LCB_DEPTH     = 4;
    localparam int LCB_ROB_IDX_W = 5;
    localparam int LCB_XLEN      = 32;

    // One buffered load completion, exactly as broadcast by MemAccess.
    typedef struct packed {
        logic [LCB_ROB_IDX_W-1:0] rob_tag;
        logic                     exc_valid;
        logic [3:0]               exc_cause;
        logic [LCB_XLEN-1:0]      mtval;
    } load_cmt_entry_t;

endpackage

// File: rtl/load_commit_buffer_fifo_ctrl.sv
// Pointer/occupancy bookkeeping for the load-completion FIFO.
// Flush dominates push and pop; a push is only taken when a slot is free,
// counting the slot released by a same-cycle pop.
import load_commit_buffer_pkg::*;

module lcb_fifo_ctrl #(
    parameter int DEPTH = LCB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic                     cmt_ready,
    output logic                     push,
    output logic                     pop,
    output logic                     drop,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Full/empty come from the occupancy count alone.
    always_comb begin
        full  = (count == CNT_W'(DEPTH));
        empty = (count == '0);
        pop   = ~empty & cmt_ready & ~flush;
        push  = in_valid & (~full | pop) & ~flush;
        drop  = in_valid & full & ~pop & ~flush;
    end

    // Pointers and count; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/load_commit_buffer.sv
// ROB-side receiver for MemAccess load completions: buffers completions in
// an in-order FIFO, drains them to the shared ROB marking port, throttles
// MemAccess near full and discards everything on flush.
import load_commit_buffer_pkg::*;

module load_commit_buffer #(
    parameter int DEPTH     = LCB_DEPTH,
    parameter int ROB_IDX_W = LCB_ROB_IDX_W,
    parameter int XLEN      = LCB_XLEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [ROB_IDX_W-1:0]   in_rob_tag,
    input  logic                   in_exc_valid,
    input  logic [3:0]             in_exc_cause,
    input  logic [XLEN-1:0]        in_mtval,
    output logic                   stall_lsu,
    output logic                   cmt_valid,
    input  logic                   cmt_ready,
    output logic [ROB_IDX_W-1:0]   cmt_rob_tag,
    output logic                   cmt_exc_valid,
    output logic [3:0]             cmt_exc_cause,
    output logic [XLEN-1:0]        cmt_mtval,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    load_cmt_entry_t  mem [DEPTH];
    load_cmt_entry_t  in_entry;
    load_cmt_entry_t  head;

    lcb_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .cmt_ready (cmt_ready),
        .push      (push),
        .pop       (pop),
        .drop      (drop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Pack the incoming completion into the stored entry format.
    always_comb begin
        in_entry           = '0;
        in_entry.rob_tag   = in_rob_tag;
        in_entry.exc_valid = in_exc_valid;
        in_entry.exc_cause = in_exc_cause;
        in_entry.mtval     = in_mtval;
    end

    // Storage is write-only on push; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    // Head is forced to zero while empty so stale slots never reach the ROB.
    always_comb begin
        head          = empty ? '0 : mem[rd_ptr];
        cmt_valid     = ~empty;
        cmt_rob_tag   = head.rob_tag;
        cmt_exc_valid = head.exc_valid;
        cmt_exc_cause = head.exc_cause;
        cmt_mtval     = head.mtval;
        // One slot stays free for a load already in flight when stall is seen.
        stall_lsu     = (count >= CNT_W'(DEPTH - 1));
    end

    // Sticky record of a completion lost to a full buffer.
    always_ff @(posedge clk) begin
        if (rst)       overflow_err <= 1'b0;
        else if (drop) overflow_err <= 1'b1;
    end

endmodule

// File: tb/tb_load_commit_buffer.sv
// Scoreboard bench: stimulus predicts accepted completions into a queue,
// a negedge monitor compares every DUT output against that queue.
import load_commit_buffer_pkg::*;

module tb_load_commit_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_rob_tag = '0;
    logic        in_exc_valid = 1'b0;
    logic [3:0]  in_exc_cause = '0;
    logic [31:0] in_mtval = '0;
    logic        cmt_ready = 1'b0;
    logic        stall_lsu;
    logic        cmt_valid;
    logic [4:0]  cmt_rob_tag;
    logic        cmt_exc_valid;
    logic [3:0]  cmt_exc_cause;
    logic [31:0] cmt_mtval;
    logic [2:0]  count;
    logic        overflow_err;

    load_commit_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_rob_tag    (in_rob_tag),
        .in_exc_valid  (in_exc_valid),
        .in_exc_cause  (in_exc_cause),
        .in_mtval      (in_mtval),
        .stall_lsu     (stall_lsu),
        .cmt_valid     (cmt_valid),
        .cmt_ready     (cmt_ready),
        .cmt_rob_tag   (cmt_rob_tag),
        .cmt_exc_valid (cmt_exc_valid),
        .cmt_exc_cause (cmt_exc_cause),
        .cmt_mtval     (cmt_mtval),
        .count         (count),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    load_cmt_entry_t q[$];
    load_cmt_entry_t pend_entry;
    bit pend_valid = 0;
    bit pend_ovf   = 0;
    bit exp_ovf    = 0;
    bit zero_chk   = 0;
    bit started    = 0;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare the cycle's outputs against the model, then advance it.
    always @(negedge clk) begin
        if (started) begin
            int n;
            n = q.size();
            chk("count", 32'(count), 32'(n));
            chk("cmt_valid", 32'(cmt_valid), 32'(n != 0));
            chk("stall_lsu", 32'(stall_lsu), 32'(n >= DEPTH - 1));
            chk("overflow_err", 32'(overflow_err), 32'(exp_ovf));
            if (n != 0) begin
                chk("head_tag", 32'(cmt_rob_tag), 32'(q[0].rob_tag));
                chk("head_exc", 32'(cmt_exc_valid), 32'(q[0].exc_valid));
                chk("head_cause", 32'(cmt_exc_cause), 32'(q[0].exc_cause));
                chk("head_mtval", cmt_mtval, q[0].mtval);
            end
            if (zero_chk) begin
                chk("rst_tag", 32'(cmt_rob_tag), 32'd0);
                chk("rst_mtval", cmt_mtval, 32'd0);
            end
            zero_chk = 0;
            if (rst) begin
                q.delete();
                exp_ovf  = 0;
                zero_chk = 1;
            end else if (flush) begin
                q.delete();
            end else begin
                if (n != 0 && cmt_ready) void'(q.pop_front());
                if (pend_valid) q.push_back(pend_entry);
                if (pend_ovf) exp_ovf = 1;
            end
            pend_valid = 0;
            pend_ovf   = 0;
        end
    end

    // One clock of stimulus; predicts acceptance from the FIFO rules.
    task automatic cyc(input logic v, input logic [4:0] tag, input logic ev,
                       input logic [3:0] ec, input logic [31:0] mt,
                       input logic rdy, input logic fl, input logic rs);
        int  mc;
        bit  mpop;
        @(posedge clk);
        #1;
        started      = 1;
        in_valid     = v;
        in_rob_tag   = tag;
        in_exc_valid = ev;
        in_exc_cause = ec;
        in_mtval     = mt;
        cmt_ready    = rdy;
        flush        = fl;
        rst          = rs;
        mc   = q.size();
        mpop = (mc > 0) && rdy && !fl && !rs;
        pend_entry.rob_tag   = tag;
        pend_entry.exc_valid = ev;
        pend_entry.exc_cause = ec;
        pend_entry.mtval     = mt;
        pend_valid = v && !fl && !rs && ((mc < DEPTH) || mpop);
        pend_ovf   = v && !fl && !rs && (mc == DEPTH) && !mpop;
    endtask

    task automatic push_t(input logic [4:0] tag, input logic rdy);
        cyc(1'b1, tag, 1'b0, 4'd0, {27'd0, tag}, rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        // reset then idle
        cyc(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        // 3, 7, 12 buffered with ROB refusing, then drained in order
        push_t(5'd3, 1'b0);
        push_t(5'd7, 1'b0);
        push_t(5'd12, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);
        // full plus simultaneous push/pop
        for (int t = 1; t <= 4; t++) push_t(5'(t), 1'b0);
        push_t(5'd5, 1'b1);
        idle(5, 1'b1);
        // push into full buffer is dropped and flagged
        for (int t = 11; t <= 14; t++) push_t(5'(t), 1'b0);
        push_t(5'd9, 1'b0);
        idle(2, 1'b0);
        idle(5, 1'b1);
        // flush beats push and pop
        for (int t = 16; t <= 18; t++) push_t(5'(t), 1'b0);
        cyc(1'b1, 5'd20, 1'b0, 4'd0, 32'd20, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        // exception entry held stable under backpressure
        cyc(1'b1, 5'd6, 1'b1, 4'd5, 32'h8000_0004, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b0);
        idle(2, 1'b1);
        // pointer wrap with back-to-back push/pop
        for (int t = 0; t < 10; t++) push_t(5'(21 + t), 1'b1);
        idle(2, 1'b1);
        // reset in the middle of 3 buffered entries
        for (int t = 1; t <= 3; t++) push_t(5'(t), 1'b0);
        cyc(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)),
                1'($urandom), 4'($urandom), $urandom,
                ($urandom_range(0, 9) < 5), ($urandom_range(0, 99) < 3),
                ($urandom_range(0, 99) < 1));
        end
        idle(6, 1'b1);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
